// File: rtl/ch_measure_pkg.sv
// Shared types for the channel measure path: point fields and word layout.
// Software-facing word: [15:0]=v, [25:16]=t, [31]=ovf_seen, rest zero.
package ch_measure_pkg;

  localparam int V_W     = 16;
  localparam int T_W     = 10;
  localparam int POINT_W = 32;
  localparam int V_LSB   = 0;
  localparam int T_LSB   = 16;
  localparam int OVF_BIT = 31;

  typedef struct packed {
    logic           ovf;
    logic [T_W-1:0] t;
    logic [V_W-1:0] v;
  } ch_point_t;

  function automatic logic [POINT_W-1:0] pack_word(
    input ch_point_t p
  );
    logic [POINT_W-1:0] w;
    w = '0;
    w[V_LSB +: V_W] = p.v;
    w[T_LSB +: T_W] = p.t;
    w[OVF_BIT]      = p.ovf;
    return w;
  endfunction

endpackage

// File: rtl/ch_point_fifo_if.sv
// Point capture / readout bundle between measure controller, FIFO and SW.
// master drives point strobe, clr and rd_en; slave returns data and status.
interface ch_point_fifo_if #(
  parameter int DEPTH = 1024,
  parameter int V_W   = 16,
  parameter int T_W   = 10
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           point_rdy_i;
  logic [V_W-1:0] point_v_i;
  logic [T_W-1:0] point_t_i;
  logic           clr_i;
  logic           rd_en_i;
  logic [31:0]    rd_data_o;
  logic           rd_valid_o;
  logic [CW-1:0]  count_o;
  logic           empty_o;
  logic           full_o;
  logic           ovf_o;
  logic [15:0]    drop_cnt_o;
  logic           sweep_done_o;

  modport master (
    output point_rdy_i, point_v_i, point_t_i,
    output clr_i, rd_en_i,
    input  rd_data_o, rd_valid_o, count_o,
    input  empty_o, full_o, ovf_o,
    input  drop_cnt_o, sweep_done_o
  );

  modport slave (
    input  point_rdy_i, point_v_i, point_t_i,
    input  clr_i, rd_en_i,
    output rd_data_o, rd_valid_o, count_o,
    output empty_o, full_o, ovf_o,
    output drop_cnt_o, sweep_done_o
  );

endinterface

// File: rtl/ch_point_ram.sv
// Simple dual-port point RAM, DEPTH x 27, registered read port.
// Ports: clk/arstn, write (we/waddr/wdata), read (re/raddr/rdata).
module ch_point_ram
  import ch_measure_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  ch_point_t                wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output ch_point_t                rdata_o
);

  ch_point_t mem [DEPTH];
  ch_point_t rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read-before-write: a read and write to the same slot
  // (full FIFO) returns the old point.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem[raddr_i];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ch_point_fifo.sv
// Point FIFO: captures (v,t) points, tracks drops/overflow, flags sweep end.
// Ports: clk_i, arstn_i, bus (slave: point in, clr, read port, status).
module ch_point_fifo
  import ch_measure_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic    clk_i,
  input  logic    arstn_i,
  ch_point_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic          rd_valid_q, rd_valid_d;
  logic          sweep_q, sweep_d;

  logic      full, empty;
  logic      wr_en, rd_ok, drop;
  ch_point_t wpoint, rpoint;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    rd_ok = bus.rd_en_i && !empty && !bus.clr_i;
    // A read while full frees the slot this write lands in.
    wr_en = bus.point_rdy_i && (!full || bus.rd_en_i)
            && !bus.clr_i;
    drop  = bus.point_rdy_i && full && !bus.rd_en_i
            && !bus.clr_i;

    wpoint.ovf = ovf_q;
    wpoint.t   = bus.point_t_i;
    wpoint.v   = bus.point_v_i;

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    rd_valid_d = 1'b0;
    sweep_d    = 1'b0;

    if (bus.clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      count_d    = count_q + CW'(wr_en) - CW'(rd_ok);
      rd_valid_d = rd_ok;
      sweep_d    = wr_en && (&bus.point_t_i);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      sweep_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      sweep_q    <= sweep_d;
    end
  end

  ch_point_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wpoint),
    .re_i    (rd_ok),
    .raddr_i (rptr_q),
    .rdata_o (rpoint)
  );

  assign bus.rd_data_o    = pack_word(rpoint);
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.count_o      = count_q;
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.ovf_o        = ovf_q;
  assign bus.drop_cnt_o   = drop_q;
  assign bus.sweep_done_o = sweep_q;

endmodule

// File: tb/tb_ch_point_fifo.sv
// Self-checking bench for ch_point_fifo: model + scoreboard of read words.
// Scenario tasks run in sequence; a monitor checks rd_valid/data/sweep.
module tb_ch_point_fifo;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  ch_point_fifo_if #(.DEPTH(DEPTH)) bus ();

  ch_point_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sb[$];
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  logic        exp_rv = 1'b0;
  logic        exp_sw = 1'b0;
  logic [31:0] mon_w;

  always @(posedge clk) begin
    #1;
    vectors++;
    if (bus.rd_valid_o !== exp_rv) begin
      miscompares++;
      $display("FAIL rd_valid: got %b want %b", bus.rd_valid_o, exp_rv);
    end
    if (exp_rv) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty: got read, want none queued");
      end else begin
        mon_w = sb.pop_front();
        if (bus.rd_data_o !== mon_w) begin
          miscompares++;
          $display("FAIL rd_data: got %h want %h", bus.rd_data_o, mon_w);
        end
      end
    end
    vectors++;
    if (bus.sweep_done_o !== exp_sw) begin
      miscompares++;
      $display("FAIL sweep: got %b want %b", bus.sweep_done_o, exp_sw);
    end
    exp_rv = 1'b0;
    exp_sw = 1'b0;
  end

  task automatic cyc(input logic rdy, input logic [15:0] v,
                     input logic [9:0] t, input logic rd,
                     input logic clr);
    logic full, empty, r, w, d;
    bus.point_rdy_i = rdy;
    bus.point_v_i   = v;
    bus.point_t_i   = t;
    bus.rd_en_i     = rd;
    bus.clr_i       = clr;
    full  = (m_count == DEPTH);
    empty = (m_count == 0);
    r = 1'b0; w = 1'b0; d = 1'b0;
    if (clr) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_drop  = '0;
    end else begin
      r = rd && !empty;
      w = rdy && (!full || rd);
      d = rdy && full && !rd;
      if (w) sb.push_back({m_ovf, 5'b0, t, v});
      if (d) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      m_count = m_count + int'(w) - int'(r);
    end
    exp_rv = r;
    exp_sw = w && (t == 10'h3FF);
    @(posedge clk);
    #2;
    bus.point_rdy_i = 1'b0;
    bus.rd_en_i     = 1'b0;
    bus.clr_i       = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    vectors++;
    if (bus.count_o !== 11'(m_count) || bus.ovf_o !== m_ovf ||
        bus.drop_cnt_o !== m_drop ||
        bus.empty_o !== (m_count == 0) ||
        bus.full_o !== (m_count == DEPTH)) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d ovf=%b drop=%0d e=%b f=%b want cnt=%0d ovf=%b drop=%0d",
               tag, bus.count_o, bus.ovf_o, bus.drop_cnt_o,
               bus.empty_o, bus.full_o, m_count, m_ovf, m_drop);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (bus.count_o !== 11'd0 || bus.empty_o !== 1'b1 ||
        bus.full_o !== 1'b0 || bus.ovf_o !== 1'b0 ||
        bus.drop_cnt_o !== 16'd0 || bus.rd_data_o !== 32'd0 ||
        bus.rd_valid_o !== 1'b0 || bus.sweep_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got cnt=%0d e=%b f=%b data=%h want 0/1/0/0",
               bus.count_o, bus.empty_o, bus.full_o, bus.rd_data_o);
    end
    #20 arstn = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_basic();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00000005;
    exp_w[1] = 32'h00010009;
    exp_w[2] = 32'h00020002;
    cyc(1'b1, 16'd5, 10'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'd9, 10'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'd2, 10'd2, 1'b0, 1'b0);
    chk_status("basic_cnt3");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
      vectors++;
      if (bus.rd_data_o !== exp_w[i]) begin
        miscompares++;
        $display("FAIL basic_word%0d: got %h want %h",
                 i, bus.rd_data_o, exp_w[i]);
      end
    end
    @(posedge clk);
    #2;
    vectors++;
    if (bus.rd_data_o !== exp_w[2]) begin
      miscompares++;
      $display("FAIL basic_hold: got %h want %h", bus.rd_data_o, exp_w[2]);
    end
    chk_status("basic_empty");
  endtask

  task automatic fill_to_full(input logic [15:0] base);
    while (m_count < DEPTH)
      cyc(1'b1, base + 16'(m_count), 10'(m_count % 512), 1'b0, 1'b0);
  endtask

  task automatic test_fill_drop();
    fill_to_full(16'd0);
    chk_status("fill_full");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'hAAAA, 10'h0AA, 1'b0, 1'b0);
    chk_status("fill_drop3");
    vectors++;
    if (bus.drop_cnt_o !== 16'd3 || bus.ovf_o !== 1'b1) begin
      miscompares++;
      $display("FAIL drop3: got drop=%0d ovf=%b want 3 1",
               bus.drop_cnt_o, bus.ovf_o);
    end
    cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
    vectors++;
    if (bus.rd_data_o !== 32'h00000000) begin
      miscompares++;
      $display("FAIL first_word: got %h want 00000000", bus.rd_data_o);
    end
    chk_status("fill_after_read");
  endtask

  task automatic test_full_rw();
    cyc(1'b1, 16'h1234, 10'h055, 1'b0, 1'b0);
    chk_status("full_again");
    cyc(1'b1, 16'h5678, 10'h066, 1'b1, 1'b0);
    chk_status("full_rw");
    while (m_count > 0)
      cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
    vectors++;
    if (bus.rd_data_o !== 32'h80665678) begin
      miscompares++;
      $display("FAIL last_word: got %h want 80665678", bus.rd_data_o);
    end
    chk_status("drained");
  endtask

  task automatic test_empty_rw();
    cyc(1'b1, 16'h00AB, 10'h00C, 1'b1, 1'b0);
    chk_status("empty_rw");
    cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
    vectors++;
    if (bus.rd_data_o !== 32'h800C00AB) begin
      miscompares++;
      $display("FAIL empty_rw_word: got %h want 800c00ab", bus.rd_data_o);
    end
    cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
    chk_status("empty_rd_ignored");
  endtask

  task automatic test_sweep();
    cyc(1'b1, 16'h0777, 10'h3FF, 1'b0, 1'b0);
    vectors++;
    if (bus.sweep_done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_pulse: got %b want 1", bus.sweep_done_o);
    end
    @(posedge clk);
    #2;
    vectors++;
    if (bus.sweep_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_once: got %b want 0", bus.sweep_done_o);
    end
    fill_to_full(16'h4000);
    cyc(1'b1, 16'h0888, 10'h3FF, 1'b0, 1'b0);
    vectors++;
    if (bus.sweep_done_o !== 1'b0 || bus.drop_cnt_o !== 16'd4) begin
      miscompares++;
      $display("FAIL sweep_drop: got sw=%b drop=%0d want 0 4",
               bus.sweep_done_o, bus.drop_cnt_o);
    end
  endtask

  task automatic test_clr();
    while (m_count > 5)
      cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
    chk_status("pre_clr");
    cyc(1'b1, 16'h0999, 10'h001, 1'b1, 1'b1);
    vectors++;
    if (bus.count_o !== 11'd0 || bus.ovf_o !== 1'b0 ||
        bus.drop_cnt_o !== 16'd0 || bus.rd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clr: got cnt=%0d ovf=%b drop=%0d rv=%b want 0",
               bus.count_o, bus.ovf_o, bus.drop_cnt_o, bus.rd_valid_o);
    end
    @(posedge clk);
    #2;
    chk_status("post_clr");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'(i + 16'h30), 10'(i), 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 10'd0, 1'b1, 1'b0);
    #1 arstn = 1'b0;
    #1;
    vectors++;
    if (bus.count_o !== 11'd0 || bus.empty_o !== 1'b1 ||
        bus.rd_valid_o !== 1'b0 || bus.rd_data_o !== 32'd0 ||
        bus.full_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: got cnt=%0d e=%b rv=%b data=%h want 0/1/0/0",
               bus.count_o, bus.empty_o, bus.rd_valid_o, bus.rd_data_o);
    end
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_drop  = '0;
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #2;
    chk_status("after_rst");
  endtask

  initial begin
    bus.point_rdy_i = 1'b0;
    bus.point_v_i   = '0;
    bus.point_t_i   = '0;
    bus.rd_en_i     = 1'b0;
    bus.clr_i       = 1'b0;
    test_reset();
    test_basic();
    test_fill_drop();
    test_full_rw();
    test_empty_rw();
    test_sweep();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ch_point_fifo.md
Name: ch_point_fifo

Overview:
- Downstream of the channel measure controller; captures every measured (threshold, delay-code) point pulsed on point_rdy.
- Buffers points in a power-of-two FIFO for software readout over a registered read port.
- Tracks overflow and dropped points, and flags end of a delay sweep.

Parameters:
DEPTH, 1024, FIFO depth in points; power of two, >= 4
V_W, 16, threshold (voltage) field width
T_W, 10, delay-code (time) field width

Ports:
clk_i  in  1  system clock
arstn_i  in  1  reset, asynchronous, active-low
point_rdy_i  in  1  one-cycle strobe: point_v_i/point_t_i valid
point_v_i  in  V_W  measured threshold code
point_t_i  in  T_W  measured delay code
clr_i  in  1  synchronous flush of FIFO and status
rd_en_i  in  1  read request (pop)
rd_data_o  out  32  popped word: [15:0]=v, [25:16]=t, [30:26]=0, [31]=ovf_seen
rd_valid_o  out  1  one-cycle pulse, rd_data_o valid
count_o  out  $clog2(DEPTH)+1  stored points
empty_o  out  1  count_o==0
full_o  out  1  count_o==DEPTH
ovf_o  out  1  sticky: at least one point dropped since reset/clr
drop_cnt_o  out  16  dropped-point counter, saturates at 16'hFFFF
sweep_done_o  out  1  one-cycle pulse: point with point_t_i == all-ones was accepted

Behaviour:
- Reset (arstn_i low, any time, including mid-operation):
  - pointers, count_o, ovf_o, drop_cnt_o, rd_data_o, rd_valid_o and sweep_done_o go to 0.
  - empty_o=1, full_o=0; RAM contents are don't-care.
- Write:
  - point_rdy_i=1 and not full (as registered at the start of the cycle): store {ovf_o, point_t_i, point_v_i} at the write pointer; wptr+1 wraps mod DEPTH.
  - Point visible to a read on the next cycle (count_o updates next edge).
- Drop:
  - point_rdy_i=1 while full and no rd_en_i: point discarded; ovf_o<=1; drop_cnt_o+1, saturating.
- Read:
  - rd_en_i=1 and not empty: RAM read at rptr; rptr+1 wraps.
  - rd_data_o registered; rd_valid_o=1 exactly one cycle after rd_en_i (latency 1).
  - rd_data_o holds its last value otherwise.
- rd_en_i while empty: ignored; no pointer change, rd_valid_o stays 0, no underflow.
- Simultaneous write + read:
  - Not empty and not full: both happen; count_o unchanged.
  - Full: read frees a slot, write accepted, no drop; count stays DEPTH.
  - Empty: write accepted, read ignored (no fall-through); count becomes 1.
- ovf_seen bit (word[31]): value of ovf_o at write time. Software uses it to detect a gap before that point.
- sweep_done_o: pulses the cycle after an accepted write with point_t_i == {T_W{1}}. Dropped points never pulse it.
- clr_i:
  - Next edge: pointers, count_o, ovf_o, drop_cnt_o cleared; rd_valid_o=0.
  - Priority over write and read in the same cycle; both are discarded, with no drop counted.
- Count arithmetic: width $clog2(DEPTH)+1; full/empty derived from count, not from pointer compare.
- Single clock domain; no CDC inside.

Decomposition:
- Shared package ch_measure_pkg holds:
  - V_W/T_W defaults and POINT_W=32.
  - Field offsets V_LSB=0, T_LSB=16, OVF_BIT=31.
  - typedef struct packed ch_point_t {ovf, t, v}, used by the controller and software-facing register blocks.
- One sub-module: ch_point_ram.
  - Simple dual-port RAM, DEPTH x 27: one write port, one registered read port.
  - Inferable as block RAM; its read register is the source of rd_data_o.

Test Plan:
- Reset, then 3 points (v=5,t=0),(v=9,t=1),(v=2,t=2), then 3 reads -> words 0x00000005, 0x00010009, 0x00020002 in order; rd_valid_o 1 cycle after each rd_en_i; empty_o=1 at end.
- Fill to DEPTH=1024, then 3 more points -> full_o=1, ovf_o=1, drop_cnt_o=3; first read returns the first point with bit31=0.
- Full, then point_rdy_i and rd_en_i in the same cycle -> count_o stays 1024, drop_cnt_o unchanged; after draining, the last word carries bit31 = ovf_o at its write.
- Empty, point_rdy_i and rd_en_i in the same cycle -> no rd_valid_o, count_o=1; next read returns that point.
- Write point t=10'h3FF -> sweep_done_o pulses once; same while full -> no pulse, drop counted.
- clr_i together with write/read at count 5 -> count_o=0, ovf_o=0, drop_cnt_o=0, no rd_valid_o. arstn_i low mid-burst -> all outputs 0 asynchronously.
